// File: rtl/dds_nco.sv
// ---------------------------------------------------------------------------
// dds_nco : numerically controlled oscillator (direct digital synthesis)
//
// A phase accumulator advances by freq_res every clock. The top 8 bits of
// the accumulator plus the phase offset address a quarter-wave sine table,
// and the table output is unfolded by quadrant symmetry into an 8-bit
// offset-binary sample. The sample is registered.
//
// Parameters:
//   ACC_W     phase accumulator width (8..16); f_out = f_clk*freq_res/2^ACC_W
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous reset, active-low (acc -> 0, out -> 8'h80)
//   phase     phase offset, 1 LSB = 360/256 degrees, sampled every clock
//   freq_res  accumulator increment 0..63, sampled every clock
//   out       registered sine sample, unsigned, mid-scale 8'h80, range 1..255
// ---------------------------------------------------------------------------
module dds_nco #(
  parameter int ACC_W = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] phase,
  input  logic [5:0] freq_res,
  output logic [7:0] out
);

  logic [ACC_W-1:0] acc_r;
  logic [7:0]       addr_s;
  logic [6:0]       idx_s;
  logic [6:0]       mag_s;
  logic [7:0]       sin_s;

  // First quadrant magnitude: round(127*sin(pi/2 * idx/64)), idx 0..64.
  function automatic logic [6:0] quarter_sin(input logic [6:0] idx);
    logic [6:0] v;
    case (idx)
      7'd0:  v = 7'd0;    7'd1:  v = 7'd3;    7'd2:  v = 7'd6;
      7'd3:  v = 7'd9;    7'd4:  v = 7'd12;   7'd5:  v = 7'd16;
      7'd6:  v = 7'd19;   7'd7:  v = 7'd22;   7'd8:  v = 7'd25;
      7'd9:  v = 7'd28;   7'd10: v = 7'd31;   7'd11: v = 7'd34;
      7'd12: v = 7'd37;   7'd13: v = 7'd40;   7'd14: v = 7'd43;
      7'd15: v = 7'd46;   7'd16: v = 7'd49;   7'd17: v = 7'd51;
      7'd18: v = 7'd54;   7'd19: v = 7'd57;   7'd20: v = 7'd60;
      7'd21: v = 7'd63;   7'd22: v = 7'd65;   7'd23: v = 7'd68;
      7'd24: v = 7'd71;   7'd25: v = 7'd73;   7'd26: v = 7'd76;
      7'd27: v = 7'd78;   7'd28: v = 7'd81;   7'd29: v = 7'd83;
      7'd30: v = 7'd85;   7'd31: v = 7'd88;   7'd32: v = 7'd90;
      7'd33: v = 7'd92;   7'd34: v = 7'd94;   7'd35: v = 7'd96;
      7'd36: v = 7'd98;   7'd37: v = 7'd100;  7'd38: v = 7'd102;
      7'd39: v = 7'd104;  7'd40: v = 7'd106;  7'd41: v = 7'd107;
      7'd42: v = 7'd109;  7'd43: v = 7'd111;  7'd44: v = 7'd112;
      7'd45: v = 7'd113;  7'd46: v = 7'd115;  7'd47: v = 7'd116;
      7'd48: v = 7'd117;  7'd49: v = 7'd118;  7'd50: v = 7'd120;
      7'd51: v = 7'd121;  7'd52: v = 7'd122;  7'd53: v = 7'd122;
      7'd54: v = 7'd123;  7'd55: v = 7'd124;  7'd56: v = 7'd125;
      7'd57: v = 7'd125;  7'd58: v = 7'd126;  7'd59: v = 7'd126;
      7'd60: v = 7'd126;  7'd61: v = 7'd127;  7'd62: v = 7'd127;
      7'd63: v = 7'd127;  7'd64: v = 7'd127;
      default: v = 7'd0;  // idx never exceeds 64
    endcase
    return v;
  endfunction

  // Table address and quadrant unfolding from the pre-update accumulator.
  always_comb begin
    addr_s = acc_r[ACC_W-1 -: 8] + phase;
    // Quadrants 1 and 3 run the quarter table backwards (64..1).
    if (addr_s[6]) begin
      idx_s = 7'd64 - {1'b0, addr_s[5:0]};
    end else begin
      idx_s = {1'b0, addr_s[5:0]};
    end
    mag_s = quarter_sin(idx_s);
    // Second half of the cycle is the first half negated about mid-scale.
    if (addr_s[7]) begin
      sin_s = 8'd128 - {1'b0, mag_s};
    end else begin
      sin_s = 8'd128 + {1'b0, mag_s};
    end
  end

  // Phase accumulator and registered sample, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_r <= {ACC_W{1'b0}};
      out   <= 8'h80;
    end else begin
      acc_r <= acc_r + {{(ACC_W-6){1'b0}}, freq_res};
      out   <= sin_s;
    end
  end

endmodule

// File: tb/tb_dds_nco.sv
// ---------------------------------------------------------------------------
// tb_dds_nco : directed + random stimulus with a scoreboard queue. Expected
// samples come from a behavioural accumulator and a floating-point sine.
// ---------------------------------------------------------------------------
module tb_dds_nco;

  localparam int ACC_W = 10;

  logic       clk;
  logic       rst;
  logic [7:0] phase;
  logic [5:0] freq_res;
  logic [7:0] out;

  int checks   = 0;
  int failures = 0;
  int m_acc    = 0;
  logic [7:0] exp_q[$];

  dds_nco #(.ACC_W(ACC_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .phase    (phase),
    .freq_res (freq_res),
    .out      (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Golden SIN(a) = 128 + round(127*sin(2*pi*a/256)), half away from zero.
  function automatic logic [7:0] sin_ref(input int a);
    real v;
    int  r;
    v = 127.0 * $sin(2.0 * 3.14159265358979323846 * real'(a) / 256.0);
    if (v >= 0.0) r = $rtoi(v + 0.5);
    else          r = -$rtoi(-v + 0.5);
    return 8'(128 + r);
  endfunction

  // Drive one cycle, push the model's expectation, compare after the edge.
  task automatic step(input logic r, input logic [7:0] ph, input logic [5:0] fr,
                      input string tag);
    logic [7:0] e;
    logic [7:0] got;
    int a;
    @(negedge clk);
    rst = r; phase = ph; freq_res = fr;
    if (!r) begin
      exp_q.push_back(8'h80);
      m_acc = 0;
    end else begin
      a = ((m_acc >> (ACC_W - 8)) + int'(ph)) % 256;
      exp_q.push_back(sin_ref(a));
      m_acc = (m_acc + int'(fr)) % (1 << ACC_W);
    end
    @(posedge clk);
    #1;
    got = out;
    e = exp_q.pop_front();
    checks++;
    assert (got === e) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, e);
    end
  endtask

  // Compare the current output against a hand-derived constant.
  task automatic key(input logic [7:0] e, input string tag);
    checks++;
    assert (out === e) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, out, e);
    end
  endtask

  initial begin
    rst = 1'b0; phase = 8'h00; freq_res = 6'd0;

    // Reset held two clocks with live inputs, then release.
    step(1'b0, 8'h40, 6'd5, "reset0"); key(8'h80, "reset0_k");
    step(1'b0, 8'h40, 6'd5, "reset1"); key(8'h80, "reset1_k");
    step(1'b1, 8'h40, 6'd5, "release"); key(8'd255, "release_k");

    // Ramp: freq_res=1, one full 1024-clock period plus one.
    step(1'b0, 8'h00, 6'd1, "ramp_rst");
    for (int k = 1; k <= 1025; k++) begin
      step(1'b1, 8'h00, 6'd1, "ramp");
      if (k == 1)    key(8'd128, "ramp_e1");
      if (k == 129)  key(8'd218, "ramp_e129");
      if (k == 257)  key(8'd255, "ramp_e257");
      if (k == 513)  key(8'd128, "ramp_e513");
      if (k == 769)  key(8'd1,   "ramp_e769");
      if (k == 1025) key(8'd128, "ramp_period");
    end

    // Phase offset with a frozen accumulator.
    step(1'b0, 8'h00, 6'd0, "ph_rst");
    for (int k = 0; k < 3; k++) step(1'b1, 8'h23, 6'd0, "ph23");
    key(8'd224, "ph23_k");
    for (int k = 0; k < 3; k++) step(1'b1, 8'h80, 6'd0, "ph80");
    key(8'd128, "ph80_k");
    for (int k = 0; k < 3; k++) step(1'b1, 8'h0F, 6'd0, "ph0f");
    key(8'd174, "ph0f_k");

    // Frequency changes without accumulator discontinuity.
    for (int k = 0; k < 40; k++) step(1'b1, 8'h00, 6'd61, "f61");
    for (int k = 0; k < 20; k++) step(1'b1, 8'h10, 6'd15, "f15");
    for (int k = 0; k < 20; k++) step(1'b1, 8'h10, 6'd31, "f31");

    // Mid-run single-edge reset.
    step(1'b0, 8'h55, 6'd31, "mid_rst"); key(8'h80, "mid_rst_k");
    step(1'b1, 8'h55, 6'd31, "mid_post"); key(8'd239, "mid_post_k");

    // Exhaustive table: freq_res=4 walks addr through 0..255.
    step(1'b0, 8'h00, 6'd4, "tbl_rst");
    for (int k = 0; k < 256; k++) begin
      step(1'b1, 8'h00, 6'd4, "table");
      if (k == 192) key(8'd1, "table_192");
    end

    // Random inputs every cycle with occasional resets.
    for (int k = 0; k < 300; k++) begin
      step(($urandom_range(0, 19) != 0), 8'($urandom_range(0, 255)),
           6'($urandom_range(0, 63)), "random");
    end

    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL sb_empty observed=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dds_nco.md
Name: dds_nco

Overview:
- Numerically controlled oscillator (direct digital synthesis) producing an 8-bit sampled sine wave.
- A phase accumulator advances by a 6-bit frequency tuning word every clock.
- An 8-bit phase offset is added to the accumulator's top bits, and the sum addresses a sine lookup.
- Sits between the control/register block, which supplies tuning word and phase, and a DAC or downstream digital filter.

Parameters:
- ACC_W, 10, phase accumulator width in bits. Legal range 8..16. Output frequency = f_clk * freq_res / 2^ACC_W.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-low. rst==0 at a rising edge resets.
- phase  input  8  phase offset, unsigned, 1 LSB = 360/256 degrees; sampled every clock.
- freq_res  input  6  frequency tuning word (accumulator increment), unsigned 0..63; sampled every clock.
- out  output  8  sine sample, unsigned offset-binary (mid-scale 0x80); registered.

Behaviour:
- One clock; reset is synchronous and active-low.
- State consists of acc[ACC_W-1:0] and the out register only.

Reset:
- On a rising edge with rst==0: acc <= 0 and out <= 8'h80.
- Inputs are ignored during reset.
- Reset asserted mid-operation takes effect on that edge with no draining.

Accumulator:
- Each rising edge with rst==1: acc <= (acc + zero_extend(freq_res)) mod 2^ACC_W.
- Wrap-around is silent, with no overflow flag.
- freq_res==0 freezes acc.

Address:
- addr[7:0] = (acc[ACC_W-1 -: 8] + phase) mod 256.
- Computed from the current (pre-update) acc register value.

Output:
- Each rising edge with rst==1: out <= SIN(addr).
- SIN(a) = 128 + round(127*sin(2*pi*a/256)) for a in 0..255; round half away from zero.
- out range is 1..255; 0 is never produced.
- Key points: SIN(0)=128, SIN(32)=218, SIN(64)=255, SIN(128)=128, SIN(192)=1.

Latency:
- out reflects the accumulator value one clock before the update edge.
- phase and freq_res changes affect out on the next edge (phase) and the edge after next (freq_res).

Implementation constraints:
- Table may be a full 256-entry ROM or a quarter-wave table (entries 0..64) with quadrant symmetry:
  - quadrant 1 mirrors the index;
  - quadrants 2–3 negate about 128.
- Results must be bit-identical to SIN().
- Purely synchronous logic; no latches; no combinational path from inputs to out.
- Inputs may change every cycle with no handshake; no glitch requirements beyond registered output.

Test Plan:
- Reset: hold rst=0 for 2 clocks with freq_res=5, phase=0x40 -> out==0x80 each edge; first edge after release gives out==SIN(0x40)==255.
- Ramp (ACC_W=10): rst released, freq_res=1, phase=0 -> edge k after release gives out==SIN((k-1)>>2); edge 1 out=128, edge 129 out=218, edge 257 out=255, edge 769 out=1; period exactly 1024 clocks.
- Phase offset: freq_res=0, acc=0 after reset; apply phase=0x23, then 0x80, then 0x0F -> out follows next edge with 0x23 giving SIN(35), 0x80 giving 128, 0x0F giving SIN(15); out held constant while inputs are held.
- Frequency change: freq_res=61 -> acc increments by 61 and wraps modulo 1024 (e.g. acc 1000 -> 37); out period ≈16.8 clocks. Switching to 15 then 31 changes step with no phase discontinuity in acc.
- Mid-run reset: with freq_res=31 running, pulse rst=0 for one edge -> that edge gives out==0x80 and acc==0; next edge gives out==SIN(phase).
- Exhaustive table check: freq_res=4, phase=0 -> 256 consecutive outputs equal SIN(0..255) against a golden model.
